// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and byte-enable helper for the data memory controller
//
// Purpose: access-size and FSM state enums, plus the byte-lane mask helper
//          used by the store path.
// Ports:   none (package).
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } size_e;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_e;

   // Byte lanes touched by an access of the given size at byte offset off.
   // The illegal size encoding yields no lanes.
   function automatic logic [3:0] be_mask(size_e size, logic [1:0] off);
      logic [3:0] m;
      case (size)
         SZ_B:    m = 4'b0001 << off;
         SZ_H:    m = 4'b0011 << off;
         SZ_W:    m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for stores and loads
//
// Purpose: purely combinational lane logic.
//   Store side: replicates right-justified store data across the word and
//               produces the byte enables for size/offset.
//   Load side:  extracts the addressed byte/halfword from a read word and
//               sign- or zero-extends it.
// Ports:
//   st_size, st_off, st_wdata   store request size, byte offset, raw data
//   st_wdata_rep, st_be         replicated data and byte enables
//   ld_size, ld_off, ld_unsigned, ld_word   registered load descriptor and word
//   ld_data                     extended load result
module dmem_lane_align
   import dmem_pkg::*;
(
   input  size_e       st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_wdata,
   output logic [31:0] st_wdata_rep,
   output logic [3:0]  st_be,
   input  size_e       ld_size,
   input  logic [1:0]  ld_off,
   input  logic        ld_unsigned,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [31:0] ld_shift;

   always_comb begin
      st_wdata_rep = st_wdata;
      case (st_size)
         SZ_B:    st_wdata_rep = {4{st_wdata[7:0]}};
         SZ_H:    st_wdata_rep = {2{st_wdata[15:0]}};
         default: st_wdata_rep = st_wdata;
      endcase
      st_be = be_mask(st_size, st_off);
   end

   // Bring the addressed lane down to bit 0, then extend from the access width.
   always_comb begin
      ld_shift = ld_word >> {ld_off, 3'b000};
      ld_data  = ld_word;
      case (ld_size)
         SZ_B:    ld_data = ld_unsigned ? {24'h0, ld_shift[7:0]}
                                        : {{24{ld_shift[7]}}, ld_shift[7:0]};
         SZ_H:    ld_data = ld_unsigned ? {16'h0, ld_shift[15:0]}
                                        : {{16{ld_shift[15]}}, ld_shift[15:0]};
         default: ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - word-organised data RAM with valid/ready requests and byte/half/word access
//
// Purpose: RAM array, zero-fill FSM and one-cycle registered response path.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   req_valid/req_ready request handshake
//   req_we, req_addr, req_wdata, req_size, req_unsigned   request fields
//   rsp_valid, rsp_rdata, rsp_err                          one-cycle response
//   busy                high while the post-reset zero-fill runs
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH          = 64,
   parameter bit CLEAR_ON_RESET = 1'b1,
   parameter int IDX_W          = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   logic [31:0]      mem [DEPTH];
   state_e           state, state_nxt;
   logic [IDX_W-1:0] cnt, cnt_nxt;

   size_e            size;
   logic [IDX_W-1:0] idx;
   logic [1:0]       off;
   logic             hs, err, wr_en, rd_en;
   logic [31:0]      wdata_rep;
   logic [3:0]       be;

   logic             rsp_ld;
   size_e            rsp_size;
   logic [1:0]       rsp_off;
   logic             rsp_uns;
   logic [31:0]      rd_word;
   logic [31:0]      ld_data;

   // Ready and busy are forced to their reset values while reset is held,
   // independent of the state register.
   assign req_ready = !reset && (state == IDLE);
   assign busy      = reset ? CLEAR_ON_RESET : (state == CLEAR);

   assign size = size_e'(req_size);
   assign idx  = req_addr[IDX_W+1:2];
   assign off  = req_addr[1:0];
   assign hs   = req_valid && req_ready;

   // Any address bit above the array span means out of range.
   assign err = (req_size == 2'b11)
             || (size == SZ_H && req_addr[0])
             || (size == SZ_W && req_addr[1:0] != 2'b00)
             || (|req_addr[31:IDX_W+2]);

   assign wr_en = hs && req_we && !err;
   assign rd_en = hs && !req_we && !err;

   dmem_lane_align u_align (
      .st_size      (size),
      .st_off       (off),
      .st_wdata     (req_wdata),
      .st_wdata_rep (wdata_rep),
      .st_be        (be),
      .ld_size      (rsp_size),
      .ld_off       (rsp_off),
      .ld_unsigned  (rsp_uns),
      .ld_word      (rd_word),
      .ld_data      (ld_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CLEAR_ON_RESET ? CLEAR : IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         CLEAR: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST_IDX) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == CLEAR) begin
            mem[cnt] <= '0;
         end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
         end
      end
   end

   // The load word is captured at the accept edge; a store accepted the
   // previous cycle has already committed, so no bypass is required.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_ld    <= 1'b0;
         rsp_size  <= SZ_W;
         rsp_off   <= 2'b00;
         rsp_uns   <= 1'b0;
         rd_word   <= '0;
      end else begin
         rsp_valid <= hs;
         rsp_err   <= hs && err;
         rsp_ld    <= rd_en;
         if (rd_en) begin
            rd_word  <= mem[idx];
            rsp_size <= size;
            rsp_off  <= off;
            rsp_uns  <= req_unsigned;
         end
      end
   end

   assign rsp_rdata = (rsp_valid && rsp_ld) ? ld_data : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - scoreboard testbench for dmem_ctrl with byte-addressed reference model
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [1:0]  req_size = 2'b10;
   logic        req_unsigned = 1'b0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic [7:0]  model [256];
   logic [32:0] exp_q [$];

   always #5 clk = ~clk;

   dmem_ctrl #(.DEPTH(64), .CLEAR_ON_RESET(1'b1)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .busy         (busy)
   );

   function automatic bit ref_err(logic [1:0] sz, logic [31:0] a);
      return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
             (sz == 2'b10 && a[1:0] != 2'b00) || (a >= 32'd256);
   endfunction

   function automatic int nbytes(logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   // Monitor: every response is matched against the oldest expectation;
   // idle cycles must present zero data and no error.
   always @(negedge clk) begin
      logic [32:0] e;
      total++;
      if (rsp_valid) begin
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rsp_unexpected: rsp_valid=1 err=%0b rdata=%08h, required no response", rsp_err, rsp_rdata);
         end else begin
            e = exp_q.pop_front();
            if ({rsp_err, rsp_rdata} !== e) begin
               bad++;
               $display("FAIL rsp_data: got err=%0b rdata=%08h, required err=%0b rdata=%08h",
                        rsp_err, rsp_rdata, e[32], e[31:0]);
            end
         end
      end else if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
         bad++;
         $display("FAIL idle_rsp: got err=%0b rdata=%08h, required 0/0", rsp_err, rsp_rdata);
      end
   end

   task automatic check(string name, logic [31:0] got, logic [31:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s: got %08h required %08h", name, got, req);
      end
   endtask

   // Issue one request; on handshake update the model and queue the expected
   // response. use_exp substitutes a hand-computed expected load value.
   task automatic issue(logic we, logic [31:0] a, logic [31:0] wd, logic [1:0] sz,
                        logic uns, bit use_exp, logic [31:0] exp_val);
      int n;
      logic [31:0] v;
      int nb;
      @(negedge clk);
      req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = uns;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         total++; bad++;
         $display("FAIL hs_timeout: req_ready=0 after %0d cycles, required 1", n);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      nb = nbytes(sz);
      if (ref_err(sz, a)) begin
         exp_q.push_back({1'b1, 32'h0});
      end else if (we) begin
         for (int i = 0; i < nb; i++) model[a[7:0] + 8'(i)] = wd[8*i +: 8];
         exp_q.push_back({1'b0, 32'h0});
      end else begin
         v = 32'h0;
         for (int i = 0; i < nb; i++) v = v | (32'(model[a[7:0] + 8'(i)]) << (8*i));
         if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
         exp_q.push_back({1'b0, use_exp ? exp_val : v});
      end
   endtask

   task automatic idle();
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Release reset right after an edge and count cycles with busy high.
   // A load is held on the port throughout to show it is not accepted.
   task automatic fill_check(string name);
      int cycles;
      bit ready_seen;
      cycles = 0;
      ready_seen = 0;
      req_we = 1'b0; req_addr = 32'h0; req_size = 2'b10; req_valid = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      while (busy && cycles < 500) begin
         if (req_ready) ready_seen = 1;
         cycles++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      check({name, "_cycles"}, 32'(cycles), 32'd64);
      check({name, "_ready_during_fill"}, 32'(ready_seen), 32'd0);
      check({name, "_ready_after_fill"}, 32'(req_ready), 32'd1);
      for (int i = 0; i < 256; i++) model[i] = 8'h00;
   endtask

   initial begin
      logic [1:0]  sz;
      logic [31:0] a;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd1);
      check("reset_ready", 32'(req_ready), 32'd0);
      fill_check("fill1");

      // Top word reads zero after the fill
      issue(1'b0, 32'hFC, 32'h0, 2'b10, 1'b0, 1'b1, 32'h0000_0000);

      // Word store then load
      issue(1'b1, 32'h10, 32'h8BAD_F00D, 2'b10, 1'b0, 1'b0, 32'h0);
      issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b1, 32'h8BAD_F00D);

      // Byte merge and extension
      issue(1'b1, 32'h13, 32'h0000_00A5, 2'b00, 1'b0, 1'b0, 32'h0);
      issue(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b1, 32'hA5AD_F00D);
      issue(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 1'b1, 32'hFFFF_FFA5);
      issue(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 1'b1, 32'h0000_00A5);
      issue(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 1'b1, 32'hFFFF_A5AD);

      // Back-to-back store/load, no stall
      issue(1'b1, 32'h20, 32'h1234_5678, 2'b10, 1'b0, 1'b0, 32'h0);
      check("b2b_ready", 32'(req_ready), 32'd1);
      issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b1, 32'h1234_5678);

      // Errors as stores; memory must be unchanged afterwards
      issue(1'b1, 32'h22, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, 32'h0);
      issue(1'b1, 32'h21, 32'hDEAD_BEEF, 2'b01, 1'b0, 1'b0, 32'h0);
      issue(1'b1, 32'h20, 32'hDEAD_BEEF, 2'b11, 1'b0, 1'b0, 32'h0);
      issue(1'b1, 32'h100, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, 32'h0);
      issue(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0);
      issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b1, 32'h1234_5678);
      idle();

      // Randomized traffic against the model
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 15) == 0) sz = 2'b11;
         else sz = 2'($urandom_range(0, 2));
         a = 32'($urandom_range(0, 32'h10F));
         if ($urandom_range(0, 3) != 0 && sz != 2'b11)
            a = a & ~32'(nbytes(sz) - 1);
         issue(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)),
               1'b0, 32'h0);
         if ($urandom_range(0, 3) == 0) idle();
      end
      idle();
      repeat (3) @(negedge clk);

      // Reset during the fill restarts the full sequence
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (30) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("midfill_reset_busy", 32'(busy), 32'd1);
      check("midfill_reset_ready", 32'(req_ready), 32'd0);
      fill_check("fill2");

      // Previously written word is cleared again
      issue(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b1, 32'h0000_0000);
      idle();
      repeat (3) @(negedge clk);
      check("pending_responses", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
